cube_ahb_initiator: RTL and testbench
=====================================

CUBE_AHB_INITIATOR -- requirements
Module: cube_ahb_initiator

Interface
REQ-001 SHALL have port HCLK, input, 1: single clock; all logic on its rising edge.
REQ-002 SHALL have port HRESET, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port req_valid, input, 1: requester has a transfer pending.
REQ-004 SHALL have port req_ready, output, 1: initiator accepts a request this cycle.
REQ-005 SHALL have port req_write, input, 1: 1 = write, 0 = read.
REQ-006 SHALL have port req_addr, input, 32: byte address of the word.
REQ-007 SHALL have port req_wdata, input, 32: write data.
REQ-008 SHALL have port rsp_valid, output, 1: single-cycle completion pulse.
REQ-009 SHALL have port rsp_rdata, output, 32: read data, valid with rsp_valid.
REQ-010 SHALL have port rsp_err, output, 1: transfer ended in error, valid with rsp_valid.
REQ-011 SHALL have port rsp_timeout, output, 1: transfer aborted by watchdog, valid with rsp_valid.
REQ-012 SHALL have ports HADDR (output, 32), HTRANS (output, 2), HWRITE (output, 1), HSIZE (output, 3), HBURST (output, 3) and HWDATA (output, 32): the AHB-Lite master outputs.
REQ-013 SHALL have ports HRDATA (input, 32), HREADY (input, 1) and HRESP (input, 1): the AHB-Lite master inputs.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR and DATA.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high, and its fields are registered.
REQ-016 SHALL move from IDLE to ADDR on acceptance, and otherwise stay in IDLE.
REQ-017 SHALL in ADDR drive HTRANS=NONSEQ, HADDR={req_addr[31:2],2'b00}, HWRITE=req_write, HSIZE=3'b010 and HBURST=3'b000 (SINGLE).
REQ-018 SHALL hold the ADDR outputs while HREADY=0, and move to DATA when HREADY=1.
REQ-019 SHALL in DATA drive HTRANS=IDLE and HWDATA equal to the registered req_wdata; HWDATA SHALL be held stable until DATA exits.
REQ-020 SHALL wait in DATA while HREADY=0; when HREADY=1, SHALL go to IDLE and pulse rsp_valid on the next cycle.
REQ-021 SHALL on that pulse drive rsp_rdata = HRDATA captured in the completing cycle for reads, and 0 for writes.
REQ-022 SHALL set rsp_err=1 if HRESP=1 in any DATA cycle of the transfer (covers the two-cycle AHB error response); otherwise rsp_err=0.
REQ-023 SHALL give a zero-wait-state latency of acceptance at cycle N, address phase at N+1, data phase at N+2, and rsp_valid at N+3.
REQ-024 SHALL accept a new request in the same cycle rsp_valid is high, giving back-to-back throughput of one transfer per 3 cycles.
REQ-025 SHALL drive HTRANS=IDLE and all other AHB outputs to 0 in IDLE.
REQ-026 SHALL never have more than one transfer outstanding.

Reset
REQ-027 SHALL, with HRESET=1 at a clock edge, go to IDLE and force req_ready=0, rsp_valid=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0, HTRANS=IDLE, and HADDR/HWRITE/HWDATA/HSIZE/HBURST=0 (req_ready=1 from the first cycle after release).
REQ-028 SHALL, on reset mid-transfer, drop the transfer silently with no rsp_valid pulse.

Configuration
REQ-029 SHALL, with CUBE_AHB_INIT_TIMEOUT_EN defined, count consecutive HREADY=0 cycles in ADDR or DATA with an 8-bit counter cleared on every state change.
REQ-030 SHALL, with CUBE_AHB_INIT_TIMEOUT_EN defined, abort when the counter reaches 255: go to IDLE, drive HTRANS=IDLE, and pulse rsp_valid with rsp_err=1 and rsp_timeout=1.
REQ-031 SHALL, without CUBE_AHB_INIT_TIMEOUT_EN, contain no counter, tie rsp_timeout to 0, and wait on HREADY indefinitely.

Structure
REQ-032 SHALL take the HTRANS, HSIZE and HBURST encodings, the FSM state encoding and the timeout limit (255) from shared package cube_ahb_pkg.
REQ-033 SHALL contain no sub-module; the watchdog is inline logic under the macro.

Verification
REQ-034 SHALL cover a zero-wait write: req addr 0x1F80_0004, wdata 0x0000_00AB -> NONSEQ at N+1 with HADDR 0x1F80_0004, HWDATA 0xAB at N+2, rsp_valid at N+3 with rsp_err=0.
REQ-035 SHALL cover a read with 3 wait states: HRDATA=0x0000_0015 on the HREADY=1 cycle -> rsp_rdata=0x15 at N+6.
REQ-036 SHALL cover an error response: HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1 -> rsp_err=1 and rsp_timeout=0.
REQ-037 SHALL cover back-to-back requests with req_valid held high -> address phases exactly 3 cycles apart and req_ready high only in IDLE.
REQ-038 SHALL cover reset in DATA: HRESET pulsed for 1 cycle -> no rsp_valid, HTRANS=IDLE, and req_ready=1 on the first cycle after reset release.
REQ-039 SHALL cover the watchdog (macro on): HREADY held 0 -> rsp_valid with rsp_err=1 and rsp_timeout=1 after 255 stalled cycles; with the macro off -> no response.

Source files
------------

// File: rtl/cube_ahb_pkg.sv
// ============================================================================
// Module   : cube_ahb_pkg
// Brief    : Shared AHB-Lite encodings, FSM states and watchdog limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cube_ahb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] C_HSIZE_WORD    = 3'b010;
    localparam logic [2:0] C_HBURST_SINGLE = 3'b000;
    localparam logic [7:0] C_TIMEOUT_LIMIT = 8'd255;

endpackage

`default_nettype wire

// File: rtl/cube_ahb_initiator.sv
// ============================================================================
// Module   : cube_ahb_initiator
// Brief    : Single-outstanding AHB-Lite master bridging a valid/ready request
//            port; optional stall watchdog under CUBE_AHB_INIT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cube_ahb_initiator
    import cube_ahb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_acc_q, err_acc_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    // Byte lanes are irrelevant for word transfers; the address is forced aligned.
    logic        w_unused_addr;
    assign w_unused_addr = ^req_addr[1:0];

    // Gating with HRESET keeps req_ready low while reset is being sampled.
    assign req_ready = (state_q == ST_IDLE) && !HRESET;

`ifdef CUBE_AHB_INIT_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic        w_timeout_hit;
    assign w_timeout_hit = (state_q != ST_IDLE) && !HREADY &&
                           (cnt_q == C_TIMEOUT_LIMIT - 8'd1);
    assign rsp_timeout   = rsp_timeout_q;
`else
    assign rsp_timeout   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_acc_d   = err_acc_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        HADDR       = 32'd0;
        HTRANS      = C_HTRANS_IDLE;
        HWRITE      = 1'b0;
        HSIZE       = 3'b000;
        HBURST      = 3'b000;
        HWDATA      = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    write_d   = req_write;
                    addr_d    = req_addr[31:2];
                    wdata_d   = req_wdata;
                    err_acc_d = 1'b0;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                HADDR  = {addr_q, 2'b00};
                HTRANS = C_HTRANS_NONSEQ;
                HWRITE = write_q;
                HSIZE  = C_HSIZE_WORD;
                HBURST = C_HBURST_SINGLE;
                if (HREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                HWDATA = wdata_q;
                // Error is sticky so the first cycle of a two-cycle ERROR is not lost.
                if (HRESP) begin
                    err_acc_d = 1'b1;
                end
                if (HREADY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = write_q ? 32'd0 : HRDATA;
                    rsp_err_d   = err_acc_q | HRESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef CUBE_AHB_INIT_TIMEOUT_EN
    always_comb begin
        rsp_timeout_d = 1'b0;
        cnt_d         = cnt_q;
        if (w_timeout_hit) begin
            rsp_timeout_d = 1'b1;
        end
        if ((state_q != ST_IDLE) && !HREADY) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (w_timeout_hit || (state_d != state_q)) begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt_q         <= 8'd0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= 30'd0;
            wdata_q     <= 32'd0;
            err_acc_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_acc_q <= err_acc_d;
`ifdef CUBE_AHB_INIT_TIMEOUT_EN
            if (w_timeout_hit) begin
                state_q     <= ST_IDLE;
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= 32'd0;
                rsp_err_q   <= 1'b1;
            end else begin
                state_q     <= state_d;
                rsp_valid_q <= rsp_valid_d;
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= rsp_err_d;
            end
`else
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cube_ahb_initiator.sv
// ============================================================================
// Module   : tb_cube_ahb_initiator
// Brief    : Self-checking bench for cube_ahb_initiator; the watchdog section
//            follows CUBE_AHB_INIT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cube_ahb_initiator;
    import cube_ahb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;

    cube_ahb_initiator dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;
    rsp_t exp_q[$];

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw;
        int          dw;
        logic [31:0] hrdata;
        logic        resp_wait;
        logic        resp_last;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response scoreboard: every rsp_valid pulse must match the oldest expectation.
    always @(negedge HCLK) begin
        rsp_t e;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
            end
        end
    end

    task automatic run_vec(input vec_t v);
        rsp_t e;
        @(negedge HCLK);
        chk("vec_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.to    = 1'b0;
        exp_q.push_back(e);
        @(negedge HCLK);
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i <= v.aw; i++) begin
            if (i > 0) @(negedge HCLK);
            chk("addr_htrans", {30'd0, HTRANS}, {30'd0, C_HTRANS_NONSEQ});
            chk("addr_haddr", HADDR, {v.addr[31:2], 2'b00});
            chk("addr_hwrite", {31'd0, HWRITE}, {31'd0, v.write});
            chk("addr_hsize_hburst", {26'd0, HSIZE, HBURST}, {26'd0, 3'b010, 3'b000});
            chk("addr_ready_low", {31'd0, req_ready}, 32'd0);
            HREADY = (i == v.aw);
        end
        for (int i = 0; i <= v.dw; i++) begin
            @(negedge HCLK);
            chk("data_htrans", {30'd0, HTRANS}, 32'd0);
            chk("data_hwdata", HWDATA, v.wdata);
            chk("data_no_rsp", {31'd0, rsp_valid}, 32'd0);
            HREADY = (i == v.dw);
            HRESP  = (i == v.dw) ? v.resp_last : v.resp_wait;
            HRDATA = (i == v.dw) ? v.hrdata : 32'hDEAD_BEEF;
        end
        @(negedge HCLK);
        chk("rsp_timing", {31'd0, rsp_valid}, 32'd1);
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'hCAFE_0000;
    endtask

    initial begin
        rsp_t e;
        int   stalls;
        bit   done;

        HRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;

        //        write addr          wdata         aw dw hrdata        rw    rl    exp_rdata     err
        vecs[0] = '{1'b1, 32'h1F80_0004, 32'h0000_00AB, 0, 0, 32'h5555_5555, 1'b0, 1'b0, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h2000_0010, 32'h0000_0000, 0, 3, 32'h0000_0015, 1'b0, 1'b0, 32'h0000_0015, 1'b0};
        vecs[2] = '{1'b0, 32'h4000_0008, 32'h0000_0000, 0, 1, 32'h0000_0000, 1'b1, 1'b1, 32'h0,         1'b1};
        vecs[3] = '{1'b0, 32'h1234_5677, 32'h0BAD_F00D, 2, 0, 32'hA5A5_0F0F, 1'b0, 1'b0, 32'hA5A5_0F0F, 1'b0};
        vecs[4] = '{1'b1, 32'h8000_0002, 32'h1357_9BDF, 1, 2, 32'h7777_7777, 1'b1, 1'b0, 32'h0,         1'b1};
        vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};

        repeat (3) @(negedge HCLK);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_flags", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_ctrl", {25'd0, HWRITE, HSIZE, HBURST}, 32'd0);
        HRESET = 1'b0;
        #1 chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back writes with req_valid held: one transfer every 3 cycles.
        for (int c = 0; c < 9; c++) begin
            @(negedge HCLK);
            chk("b2b_ready", {31'd0, req_ready}, (c % 3 == 0) ? 32'd1 : 32'd0);
            chk("b2b_htrans", {30'd0, HTRANS},
                (c % 3 == 1) ? {30'd0, C_HTRANS_NONSEQ} : 32'd0);
            if (c % 3 == 1) chk("b2b_haddr", HADDR, 32'h100 + (c - 1) * 4);
            if (c % 3 == 2) chk("b2b_hwdata", HWDATA, c - 2);
            if (c % 3 == 0) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = 32'h100 + c * 4;
                req_wdata = c;
                e.rdata = 32'd0; e.err = 1'b0; e.to = 1'b0;
                exp_q.push_back(e);
            end
            if (c == 8) req_valid = 1'b0;
        end

        // Reset while the data phase is stalled: transfer dropped without a response.
        @(negedge HCLK);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h0000_BEEF;
        @(negedge HCLK);
        req_valid = 1'b0; HREADY = 1'b1;
        @(negedge HCLK);
        HREADY = 1'b0;
        chk("rstd_in_data", HWDATA, 32'h0000_BEEF);
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("rstd_ready_low", {31'd0, req_ready}, 32'd0);
        chk("rstd_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rstd_no_rsp", {31'd0, rsp_valid}, 32'd0);
        HRESET = 1'b0; HREADY = 1'b1;
        #1 chk("rstd_release_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge HCLK);

        // Watchdog: HREADY held low from the address phase onward.
        @(negedge HCLK);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0080;
        @(negedge HCLK);
        req_valid = 1'b0; HREADY = 1'b0;
`ifdef CUBE_AHB_INIT_TIMEOUT_EN
        e.rdata = 32'd0; e.err = 1'b1; e.to = 1'b1;
        exp_q.push_back(e);
        stalls = 0;
        done   = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
            end else begin
                stalls++;
                @(negedge HCLK);
            end
        end
        chk("wd_fired", {31'd0, done}, 32'd1);
        chk("wd_stall_cycles", stalls, 32'd255);
        chk("wd_htrans_idle", {30'd0, HTRANS}, 32'd0);
        HREADY = 1'b1;
`else
        repeat (300) @(negedge HCLK);
        chk("nowd_still_waiting", {30'd0, HTRANS}, {30'd0, C_HTRANS_NONSEQ});
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0; HREADY = 1'b1;
`endif
        repeat (4) @(negedge HCLK);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
